// File: rtl/test_74hc595_pkg.sv
// Shared types and defaults for the 74HC595 demo driver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package test_74hc595_pkg;

  localparam int CLK_HZ              = 50_000_000;
  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;  // 20 ms at CLK_HZ
  localparam int DEF_SCLK_DIV        = 25;         // 1 MHz serial clock at CLK_HZ

  typedef enum logic [1:0] {
    LOAD     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    LATCH    = 2'd3
  } state_t;

  // Counter width able to hold 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchronises and debounces an active-low key, emitting a one-cycle press pulse.
// Latency: press pulses DEBOUNCE_CYCLES+2 cycles after the key settles low.
// Backpressure: none; the pulse is fire-and-forget.
module key_debounce
  import test_74hc595_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic press
);

  localparam int              CW       = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q, sync_d;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;

  // Accept a new level only after it has been seen on every one of DEBOUNCE_CYCLES cycles.
  always_comb begin
    sync_d   = {sync_q[0], key};
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync_q[1] != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    // Falling edge of the accepted level is a press; release is ignored.
    press_d = stable_q & ~stable_d;
  end

  // Synchroniser and stable level reset to the released (high) state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q   <= 2'b11;
      stable_q <= 1'b1;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/test_74hc595.sv
// Counts debounced key presses and continuously refreshes a 74HC595 with the count, MSB first.
// Latency: a new count shows on the latch at the end of the first frame whose LOAD follows the press.
// Backpressure: none; frames free-run at 2*DATA_W+2 ticks each.
module test_74hc595
  import test_74hc595_pkg::*;
#(
  parameter int DATA_W          = 8,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int SCLK_DIV        = DEF_SCLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic lock595,
  output logic out595,
  output logic clk595
);

  localparam int            DW       = cnt_w(SCLK_DIV);
  localparam int            BW       = cnt_w(DATA_W);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

  logic              press;
  logic              tick;
  logic [DW-1:0]     div_q, div_d;
  logic [DATA_W-1:0] value_q, value_d;
  state_t            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [BW-1:0]     bitcnt_q, bitcnt_d;
  logic              clk595_q, clk595_d;
  logic              out595_q, out595_d;
  logic              lock595_q, lock595_d;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .clk  (clk),
    .rst  (rst),
    .key  (key),
    .press(press)
  );

  // Free-running divider: one tick per serial half-period.
  always_comb begin
    tick  = (div_q == DIV_LAST);
    div_d = tick ? '0 : div_q + DW'(1);
  end

  // Display value wraps naturally at 2^DATA_W.
  always_comb begin
    value_d = value_q + DATA_W'(press);
  end

  // Frame sequencer: data moves on clk595 falling edges, latch pulses once after the last bit.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bitcnt_d  = bitcnt_q;
    clk595_d  = clk595_q;
    out595_d  = out595_q;
    lock595_d = lock595_q;
    if (tick) begin
      case (state_q)
        LOAD: begin
          // shreg holds the bits still to be sent, left-aligned.
          shreg_d  = {value_q[DATA_W-2:0], 1'b0};
          out595_d = value_q[DATA_W-1];
          bitcnt_d = '0;
          state_d  = SHIFT_LO;
        end
        SHIFT_LO: begin
          clk595_d = 1'b1;
          state_d  = SHIFT_HI;
        end
        SHIFT_HI: begin
          clk595_d = 1'b0;
          if (bitcnt_q == BIT_LAST) begin
            lock595_d = 1'b1;
            state_d   = LATCH;
          end else begin
            bitcnt_d = bitcnt_q + BW'(1);
            out595_d = shreg_q[DATA_W-1];
            shreg_d  = {shreg_q[DATA_W-2:0], 1'b0};
            state_d  = SHIFT_LO;
          end
        end
        LATCH: begin
          lock595_d = 1'b0;
          out595_d  = 1'b0;
          state_d   = LOAD;
        end
        default: begin
          state_d = LOAD;
        end
      endcase
    end
  end

  // All state and outputs are registered; reset aborts any frame with outputs low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q     <= '0;
      value_q   <= '0;
      state_q   <= LOAD;
      shreg_q   <= '0;
      bitcnt_q  <= '0;
      clk595_q  <= 1'b0;
      out595_q  <= 1'b0;
      lock595_q <= 1'b0;
    end else begin
      div_q     <= div_d;
      value_q   <= value_d;
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bitcnt_q  <= bitcnt_d;
      clk595_q  <= clk595_d;
      out595_q  <= out595_d;
      lock595_q <= lock595_d;
    end
  end

  assign clk595  = clk595_q;
  assign out595  = out595_q;
  assign lock595 = lock595_q;

endmodule

// File: tb/tb_test_74hc595.sv
// Directed bench for test_74hc595 with short debounce and divider.
// Latency: frames are rebuilt from clk595 rising edges and closed on each lock595 rise.
// Backpressure: n/a.
module tb_test_74hc595;

  localparam int DB = 16;
  localparam int SD = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic key = 1'b1;
  logic lock595, out595, clk595;

  int vectors     = 0;
  int miscompares = 0;

  // Frame reconstruction state, owned by the monitor.
  int         nbits       = 0;
  int         frame_cnt   = 0;
  int         last_bits   = 0;
  int         lock_w      = 0;
  int         last_lock_w = 0;
  int         overlap     = 0;
  logic [7:0] shbits      = 8'h00;
  logic [7:0] last_frame  = 8'h00;
  logic       prev_c      = 1'b0;
  logic       prev_l      = 1'b0;

  always #10 clk = ~clk;

  test_74hc595 #(
    .DATA_W(8),
    .DEBOUNCE_CYCLES(DB),
    .SCLK_DIV(SD)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .key    (key),
    .lock595(lock595),
    .out595 (out595),
    .clk595 (clk595)
  );

  // Monitor: sample outputs on the falling clk edge, rebuild each shifted byte.
  always @(negedge clk) begin
    if (!rst) begin
      nbits  = 0;
      shbits = 8'h00;
      lock_w = 0;
      prev_c = 1'b0;
      prev_l = 1'b0;
    end else begin
      if (clk595 && lock595) overlap++;
      if (clk595 && !prev_c) begin
        shbits = {shbits[6:0], out595};
        nbits++;
      end
      if (lock595 && !prev_l) begin
        last_frame = shbits;
        last_bits  = nbits;
        nbits      = 0;
        frame_cnt++;
      end
      if (lock595) lock_w++;
      if (!lock595 && prev_l) begin
        last_lock_w = lock_w;
        lock_w      = 0;
      end
      prev_c = clk595;
      prev_l = lock595;
    end
  end

  // Global time limit so the bench can never hang.
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation still running at time limit, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic wait_frame();
    int start;
    start = frame_cnt;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (frame_cnt != start) return;
    end
    vectors++;
    miscompares++;
    $display("FAIL frame_timeout: no lock595 pulse within 400 cycles, required one");
  endtask

  task automatic press(input int lo, input int hi);
    key = 1'b0;
    repeat (lo) @(negedge clk);
    key = 1'b1;
    repeat (hi) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    key = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (lock595 !== 1'b0) begin miscompares++; $display("FAIL rst_lock595: got %b, want 0", lock595); end
    vectors++;
    if (out595 !== 1'b0) begin miscompares++; $display("FAIL rst_out595: got %b, want 0", out595); end
    vectors++;
    if (clk595 !== 1'b0) begin miscompares++; $display("FAIL rst_clk595: got %b, want 0", clk595); end
    rst = 1'b1;
    // Ticks land on the 2nd and 4th edges after release; clk595 rises on the second tick.
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (clk595 !== 1'b0) begin miscompares++; $display("FAIL first_tick_early: clk595 got %b, want 0", clk595); end
    @(posedge clk);
    #1;
    vectors++;
    if (clk595 !== 1'b1) begin miscompares++; $display("FAIL first_tick: clk595 got %b, want 1", clk595); end
    wait_frame();
    wait_frame();
    wait_frame();
    vectors++;
    if (last_frame !== 8'h00) begin miscompares++; $display("FAIL reset_frame: got %h, want 00", last_frame); end
    vectors++;
    if (last_bits !== 8) begin miscompares++; $display("FAIL reset_bits: got %0d, want 8", last_bits); end
    vectors++;
    if (last_lock_w !== SD) begin miscompares++; $display("FAIL lock_width: got %0d, want %0d", last_lock_w, SD); end
  endtask

  task automatic test_clean_press();
    press(40, 40);
    wait_frame();
    wait_frame();
    vectors++;
    if (last_frame !== 8'h01) begin miscompares++; $display("FAIL clean_press: got %h, want 01", last_frame); end
    press(200, 40);
    wait_frame();
    wait_frame();
    vectors++;
    if (last_frame !== 8'h02) begin miscompares++; $display("FAIL long_hold: got %h, want 02", last_frame); end
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 12; i++) begin
      key = (i % 2 == 1);
      repeat (5) @(negedge clk);
    end
    press(40, 40);
    wait_frame();
    wait_frame();
    vectors++;
    if (last_frame !== 8'h03) begin miscompares++; $display("FAIL bouncy_press: got %h, want 03", last_frame); end
    press(15, 40);
    wait_frame();
    wait_frame();
    vectors++;
    if (last_frame !== 8'h03) begin miscompares++; $display("FAIL short_15: got %h, want 03", last_frame); end
    press(16, 40);
    wait_frame();
    wait_frame();
    vectors++;
    if (last_frame !== 8'h04) begin miscompares++; $display("FAIL exact_16: got %h, want 04", last_frame); end
  endtask

  task automatic test_mid_frame();
    logic prev;
    bit   found;
    prev  = lock595;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (prev && !lock595) found = 1'b1;
      prev = lock595;
    end
    vectors++;
    if (!found) begin miscompares++; $display("FAIL mid_sync: lock595 fall not seen, required one"); end
    // Key drops so the value changes during SHIFT_HI of bit 4 of the frame now starting.
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    key = 1'b0;
    wait_frame();
    vectors++;
    if (last_frame !== 8'h04) begin miscompares++; $display("FAIL mid_frame_old: got %h, want 04", last_frame); end
    key = 1'b1;
    wait_frame();
    vectors++;
    if (last_frame !== 8'h05) begin miscompares++; $display("FAIL mid_frame_new: got %h, want 05", last_frame); end
    repeat (40) @(negedge clk);
    vectors++;
    if (overlap !== 0) begin miscompares++; $display("FAIL overlap: lock595&clk595 high on %0d samples, want 0", overlap); end
  endtask

  task automatic test_wrap();
    logic [7:0] exp;
    exp = 8'h05;
    for (int n = 0; n < 256; n++) begin
      press(20, 20);
      exp = exp + 8'h01;
      wait_frame();
      wait_frame();
      vectors++;
      if (last_frame !== exp) begin
        miscompares++;
        $display("FAIL wrap_press_%0d: got %h, want %h", n, last_frame, exp);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    for (int i = 0; i < 400 && nbits < 4; i++) @(negedge clk);
    #5;
    rst = 1'b0;
    #1;
    vectors++;
    if (lock595 !== 1'b0) begin miscompares++; $display("FAIL midrst_lock595: got %b, want 0", lock595); end
    vectors++;
    if (out595 !== 1'b0) begin miscompares++; $display("FAIL midrst_out595: got %b, want 0", out595); end
    vectors++;
    if (clk595 !== 1'b0) begin miscompares++; $display("FAIL midrst_clk595: got %b, want 0", clk595); end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    wait_frame();
    vectors++;
    if (last_bits !== 8) begin miscompares++; $display("FAIL midrst_bits: got %0d, want 8", last_bits); end
    vectors++;
    if (last_frame !== 8'h00) begin miscompares++; $display("FAIL midrst_value: got %h, want 00", last_frame); end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_mid_frame();
    test_wrap();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
